// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the shared memory port and mem_port_arbiter.
// slave = arbiter side; master = requesters plus memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 24
);
  logic              f_req;
  logic              f_we;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_wdata;
  logic              f_gnt;
  logic              f_ack;
  logic [DATA_W-1:0] f_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  f_req, f_we, f_addr, f_wdata,
    output f_gnt, f_ack, f_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_ack, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output f_req, f_we, f_addr, f_wdata,
    input  f_gnt, f_ack, f_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_ack, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for the single synchronous memory port; one transaction in flight at a time.
// Define MEM_ARB_FIXED_PRIO_EN for fixed data-port priority; default is round-robin on ties.
//
// state  | meaning
// IDLE   | no transaction; arbitrate pending requests and latch the winner
// ACCESS | drive mem_en for one cycle, pulse owner gnt, load latency counter
// WAIT   | count down memory latency; capture read data on terminal count
// RESP   | pulse owner ack, record owner for round-robin
module mem_port_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 24,
  parameter int MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;

  logic              own_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] f_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic              any_req;
  logic              pick_d;
  logic              capture;

  assign any_req = bus.f_req | bus.d_req;
  assign capture = (state == WAIT) && (cnt == '0) && !we_q;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign pick_d = bus.d_req;
`else
  // last_d = 1 means the data port was served last, so fetch wins the next tie
  logic last_d;

  assign pick_d = bus.d_req && (!bus.f_req || !last_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_d <= 1'b1;
    end else if (state == RESP) begin
      last_d <= own_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        cnt_nxt   = CNT_LOAD;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      own_d     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if ((state == IDLE) && any_req) begin
        own_d   <= pick_d;
        we_q    <= pick_d ? bus.d_we    : bus.f_we;
        addr_q  <= pick_d ? bus.d_addr  : bus.f_addr;
        wdata_q <= pick_d ? bus.d_wdata : bus.f_wdata;
      end
      if (capture) begin
        if (own_d) begin
          d_rdata_q <= bus.mem_rdata;
        end else begin
          f_rdata_q <= bus.mem_rdata;
        end
      end
    end
  end

  // Outputs come only from state and registers; no req-to-output path.
  assign bus.mem_en    = (state == ACCESS);
  assign bus.mem_we    = (state == ACCESS) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.f_gnt     = (state == ACCESS) && !own_d;
  assign bus.d_gnt     = (state == ACCESS) &&  own_d;
  assign bus.f_ack     = (state == RESP)   && !own_d;
  assign bus.d_ack     = (state == RESP)   &&  own_d;
  assign bus.f_rdata   = f_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three lanes with MEM_LAT 1, 2 and 7, each with its own memory model,
// driven one lane at a time and checked against a transaction-level reference.
module tb_mem_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 24;

  logic clk = 1'b0;
  logic rst;
  int   sel;

  logic          f_req, f_we, d_req, d_we;
  logic [AW-1:0] f_addr, d_addr;
  logic [DW-1:0] f_wdata, d_wdata;

  logic          f_gnt_v [3];
  logic          d_gnt_v [3];
  logic          f_ack_v [3];
  logic          d_ack_v [3];
  logic          mem_en_v [3];
  logic          mem_we_v [3];
  logic          busy_v [3];
  logic [AW-1:0] mem_addr_v [3];
  logic [DW-1:0] mem_wdata_v [3];
  logic [DW-1:0] f_rdata_v [3];
  logic [DW-1:0] d_rdata_v [3];

  int n_checks = 0;
  int n_err    = 0;

  // reference: memory image per lane, expected held rdata per lane/port, last served port
  logic [DW-1:0] ref_mem [3][256];
  logic [DW-1:0] exp_rdata [3][2];
  bit            last_f [3];

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return {a, ~a, a ^ 8'h5A};
  endfunction

  function automatic int lat_of(input int l);
    return (l == 0) ? 1 : (l == 1) ? 2 : 7;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 2 : 7;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );

    bit [DW-1:0]   mem [256];
    bit            written [256];
    logic [DW-1:0] pipe [LAT];

    assign bus.f_req   = f_req && (sel == g);
    assign bus.f_we    = f_we;
    assign bus.f_addr  = f_addr;
    assign bus.f_wdata = f_wdata;
    assign bus.d_req   = d_req && (sel == g);
    assign bus.d_we    = d_we;
    assign bus.d_addr  = d_addr;
    assign bus.d_wdata = d_wdata;

    assign f_gnt_v[g]     = bus.f_gnt;
    assign d_gnt_v[g]     = bus.d_gnt;
    assign f_ack_v[g]     = bus.f_ack;
    assign d_ack_v[g]     = bus.d_ack;
    assign mem_en_v[g]    = bus.mem_en;
    assign mem_we_v[g]    = bus.mem_we;
    assign busy_v[g]      = bus.busy;
    assign mem_addr_v[g]  = bus.mem_addr;
    assign mem_wdata_v[g] = bus.mem_wdata;
    assign f_rdata_v[g]   = bus.f_rdata;
    assign d_rdata_v[g]   = bus.d_rdata;

    // read data is valid only in the single cycle LAT after mem_en; junk otherwise
    always @(posedge clk) begin
      if (bus.mem_en && !bus.mem_we)
        pipe[0] <= written[bus.mem_addr] ? mem[bus.mem_addr] : init_word(bus.mem_addr);
      else
        pipe[0] <= DW'($urandom);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      if (bus.mem_en && bus.mem_we) begin
        mem[bus.mem_addr]     = bus.mem_wdata;
        written[bus.mem_addr] = 1'b1;
      end
    end
    assign bus.mem_rdata = pipe[LAT-1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s lane=%0d observed=%0h expected=%0h", tag, sel, obs, exp);
    end
  endtask

  function automatic logic gnt_of(input bit p);
    return p ? d_gnt_v[sel] : f_gnt_v[sel];
  endfunction

  function automatic logic ack_of(input bit p);
    return p ? d_ack_v[sel] : f_ack_v[sel];
  endfunction

  function automatic logic [DW-1:0] rdata_of(input bit p);
    return p ? d_rdata_v[sel] : f_rdata_v[sel];
  endfunction

  // tie rule from the spec: fixed build always data, otherwise the port not served last
  function automatic bit tie_winner();
`ifdef MEM_ARB_FIXED_PRIO_EN
    return 1'b1;
`else
    return last_f[sel];
`endif
  endfunction

  task automatic drive(input bit p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    if (p) begin
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    end else begin
      f_req = 1'b1; f_we = we; f_addr = a; f_wdata = wd;
    end
  endtask

  task automatic drop(input bit p);
    if (p) d_req = 1'b0;
    else   f_req = 1'b0;
  endtask

  task automatic reset_model();
    for (int l = 0; l < 3; l++) begin
      last_f[l]       = 1'b0;
      exp_rdata[l][0] = '0;
      exp_rdata[l][1] = '0;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_f_gnt"},     32'(f_gnt_v[sel]),     32'(0));
    check({tag, "_d_gnt"},     32'(d_gnt_v[sel]),     32'(0));
    check({tag, "_f_ack"},     32'(f_ack_v[sel]),     32'(0));
    check({tag, "_d_ack"},     32'(d_ack_v[sel]),     32'(0));
    check({tag, "_mem_en"},    32'(mem_en_v[sel]),    32'(0));
    check({tag, "_mem_we"},    32'(mem_we_v[sel]),    32'(0));
    check({tag, "_busy"},      32'(busy_v[sel]),      32'(0));
    check({tag, "_mem_addr"},  32'(mem_addr_v[sel]),  32'(0));
    check({tag, "_mem_wdata"}, 32'(mem_wdata_v[sel]), 32'(0));
    check({tag, "_f_rdata"},   32'(f_rdata_v[sel]),   32'(0));
    check({tag, "_d_rdata"},   32'(d_rdata_v[sel]),   32'(0));
  endtask

  // Called in the grant cycle; returns in the following IDLE cycle.
  task automatic finish_txn(input bit p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    int n;
    int extra_en;
    bit seen;
    logic [DW-1:0] exp_rd;
    n = 0; extra_en = 0; seen = 1'b0;
    check("mem_en",    32'(mem_en_v[sel]),    32'(1));
    check("mem_we",    32'(mem_we_v[sel]),    32'(we));
    check("mem_addr",  32'(mem_addr_v[sel]),  32'(a));
    check("mem_wdata", 32'(mem_wdata_v[sel]), 32'(wd));
    if (we) begin
      ref_mem[sel][a] = wd;
      exp_rd = exp_rdata[sel][p];
    end else begin
      exp_rd = ref_mem[sel][a];
    end
    while (!seen && n < 16) begin
      tick();
      n++;
      seen = (ack_of(p) === 1'b1);
      if (mem_en_v[sel] !== 1'b0) extra_en++;
    end
    check("ack_latency", 32'(n), 32'(lat_of(sel) + 1));
    check("mem_en_once", 32'(extra_en), 32'(0));
    check("rdata", 32'(rdata_of(p)), 32'(exp_rd));
    exp_rdata[sel][p] = exp_rd;
    last_f[sel] = !p;
    tick();
    check("busy_end", 32'(busy_v[sel]), 32'(0));
  endtask

  task automatic run_txn(input bit p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    drive(p, we, a, wd);
    tick();
    check("gnt",       32'(gnt_of(p)),    32'(1));
    check("gnt_other", 32'(gnt_of(!p)),   32'(0));
    check("busy",      32'(busy_v[sel]),  32'(1));
    drop(p);
    finish_txn(p, we, a, wd);
  endtask

  task automatic serve_pair(input logic fwe, input logic [AW-1:0] fa, input logic [DW-1:0] fwd,
                            input logic dwe, input logic [AW-1:0] da, input logic [DW-1:0] dwd);
    bit w;
    drive(1'b0, fwe, fa, fwd);
    drive(1'b1, dwe, da, dwd);
    tick();
    w = tie_winner();
    check("pair_gnt_win",  32'(gnt_of(w)),  32'(1));
    check("pair_gnt_lose", 32'(gnt_of(!w)), 32'(0));
    drop(w);
    if (w) finish_txn(1'b1, dwe, da, dwd);
    else   finish_txn(1'b0, fwe, fa, fwd);
    tick();
    check("pair_gnt_next", 32'(gnt_of(!w)), 32'(1));
    drop(!w);
    if (w) finish_txn(1'b0, fwe, fa, fwd);
    else   finish_txn(1'b1, dwe, da, dwd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            exp_w;
    int            any_ack;
    int            mode;
    logic          we0, we1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] wd0, wd1;

    for (int l = 0; l < 3; l++)
      for (int i = 0; i < 256; i++) ref_mem[l][i] = init_word(AW'(i));
    reset_model();
    rst = 1'b1; sel = 1;
    f_req = 1'b0; f_we = 1'b0; f_addr = '0; f_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) tick();
    for (int l = 0; l < 3; l++) begin
      sel = l;
      check_zero("reset");
    end
    rst = 1'b0;
    sel = 1;
    tick();

    // both ports requesting continuously, winner re-requests after each ack
    drive(1'b0, 1'b0, 8'h30, 24'h0);
    drive(1'b1, 1'b0, 8'h40, 24'h0);
    for (int r = 0; r < 4; r++) begin
      tick();
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_w = 1'b1;
`else
      exp_w = (r % 2) != 0;
`endif
      check("tie_model", 32'(tie_winner()), 32'(exp_w));
      check("tie_gnt_win",  32'(gnt_of(exp_w)),  32'(1));
      check("tie_gnt_lose", 32'(gnt_of(!exp_w)), 32'(0));
      drop(exp_w);
      finish_txn(exp_w, 1'b0, exp_w ? d_addr : f_addr, exp_w ? d_wdata : f_wdata);
      if (exp_w) drive(1'b1, 1'b0, 8'h41 + 8'(r), 24'h0);
      else       drive(1'b0, 1'b0, 8'h31 + 8'(r), 24'h0);
    end
    f_req = 1'b0; d_req = 1'b0;
    tick();

    // load 0xABCDEF at 0x10, then fetch-read it
    run_txn(1'b1, 1'b1, 8'h10, 24'hABCDEF);
    run_txn(1'b0, 1'b0, 8'h10, 24'h000000);
    check("fetch_abcdef", 32'(f_rdata_v[sel]), 32'h00ABCDEF);

    // data write leaves d_rdata alone
    run_txn(1'b1, 1'b0, 8'h21, 24'h0);
    run_txn(1'b1, 1'b1, 8'h20, 24'h000055);
    run_txn(1'b1, 1'b0, 8'h20, 24'h0);

    // data request raised while a fetch is in WAIT
    drive(1'b0, 1'b0, 8'h60, 24'h0);
    tick();
    check("late_f_gnt", 32'(f_gnt_v[sel]), 32'(1));
    drop(1'b0);
    tick();
    drive(1'b1, 1'b0, 8'h50, 24'h0);
    repeat (lat_of(sel)) tick();
    check("late_f_ack",   32'(f_ack_v[sel]),   32'(1));
    check("late_f_rdata", 32'(f_rdata_v[sel]), 32'(ref_mem[sel][8'h60]));
    check("late_d_hold0", 32'(d_gnt_v[sel]),   32'(0));
    exp_rdata[sel][0] = ref_mem[sel][8'h60];
    last_f[sel] = 1'b1;
    tick();
    check("late_idle",    32'(busy_v[sel]),    32'(0));
    check("late_d_hold1", 32'(d_gnt_v[sel]),   32'(0));
    tick();
    check("late_d_gnt",   32'(d_gnt_v[sel]),   32'(1));
    drop(1'b1);
    finish_txn(1'b1, 1'b0, 8'h50, 24'h0);

    // reset in the middle of WAIT drops the transaction
    drive(1'b0, 1'b0, 8'h70, 24'h0);
    tick();
    drop(1'b0);
    tick();
    rst = 1'b1;
    tick();
    check_zero("rst_wait");
    rst = 1'b0;
    reset_model();
    any_ack = 0;
    repeat (10) begin
      tick();
      if (f_ack_v[sel] !== 1'b0 || d_ack_v[sel] !== 1'b0) any_ack++;
    end
    check("rst_no_ack", 32'(any_ack), 32'(0));
    run_txn(1'b0, 1'b0, 8'h70, 24'h0);

    // randomized traffic on every latency
    for (int l = 0; l < 3; l++) begin
      sel = l;
      tick();
      for (int k = 0; k < 10; k++) begin
        mode = $urandom_range(0, 2);
        we0  = 1'($urandom_range(0, 1));
        we1  = 1'($urandom_range(0, 1));
        a0   = 8'($urandom_range(0, 15));
        a1   = 8'($urandom_range(0, 15));
        wd0  = 24'($urandom);
        wd1  = 24'($urandom);
        if (mode == 2) serve_pair(we0, a0, wd0, we1, a1, wd1);
        else           run_txn(mode != 0, we0, a0, wd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
